// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double-dabble,
// one bit per clock). Result is held between conversions for a display mux.
//
// Ports:
//   clk    in   system clock, rising edge
//   clr_n  in   asynchronous active-low reset
//   start  in   conversion request, sampled only while idle
//   bin    in   [13:0] unsigned value, captured on accepted start
//   busy   out  conversion in progress
//   done   out  one-cycle pulse, bcd/ovf updated in the same cycle
//   bcd    out  [15:0] thousands/hundreds/tens/units
//   ovf    out  last converted value exceeded 9999
//
// Build option: define BCD_SAT_EN to clamp out-of-range results to 16'h9999;
// otherwise the ten-thousands digit is dropped (value mod 10000).

module bin2bcd_seq (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state_q, state_d;
    logic [33:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;

    logic [33:0] work_adj;
    logic [33:0] work_shl;
    logic [3:0]  nib;
    logic [3:0]  tenk;
    logic [15:0] low4;

    // Add-3 on every BCD nibble >= 5, then shift; nibbles never carry
    // into each other because 9 + 3 still fits in four bits.
    always_comb begin
        work_adj = work_q;
        nib      = 4'd0;
        for (int i = 0; i < 5; i++) begin
            nib = work_q[14 + 4*i +: 4];
            if (nib >= 4'd5) begin
                work_adj[14 + 4*i +: 4] = nib + 4'd3;
            end
        end
        work_shl = {work_adj[32:0], 1'b0};
        tenk     = work_shl[33:30];
        low4     = work_shl[29:14];
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {20'b0, bin};
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = work_shl;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
`ifdef BCD_SAT_EN
                    bcd_d = (tenk != 4'd0) ? 16'h9999 : low4;
`else
                    bcd_d = low4;
`endif
                    ovf_d   = (tenk != 4'd0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, hand sequences for
// busy/reset corner cases, and random values against an arithmetic model.

module tb_bin2bcd_seq;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    int checks;
    int errors;

    logic [15:0] prev_bcd;
    logic        prev_ovf;

    bin2bcd_seq dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          val;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Reference: decimal digits by plain division.
    function automatic logic [16:0] ref_model(input int v);
        logic [15:0] r;
        logic        o;
        int          m;
        o = (v > 9999);
        m = v % 10000;
`ifdef BCD_SAT_EN
        if (o) m = 9999;
`endif
        r[15:12] = 4'((m / 1000) % 10);
        r[11:8]  = 4'((m / 100) % 10);
        r[7:4]   = 4'((m / 10) % 10);
        r[3:0]   = 4'(m % 10);
        return {o, r};
    endfunction

    // Call while idle, #1 after a rising edge. Ends #1 after the cycle
    // following done.
    task automatic run_conv(input int v, input logic [15:0] eb,
                            input logic eo);
        int cyc;
        bit got;
        start = 1'b1;
        bin   = 14'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 14'($urandom);
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                got = 1'b1;
            end else if (bcd !== prev_bcd || ovf !== prev_ovf) begin
                chk("hold_during_conv", {15'b0, ovf, bcd},
                    {15'b0, prev_ovf, prev_bcd});
            end
        end
        chk("latency", got ? cyc : -1, 14);
        chk("bcd", {16'b0, bcd}, {16'b0, eb});
        chk("ovf", {31'b0, ovf}, {31'b0, eo});
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        prev_bcd = eb;
        prev_ovf = eo;
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("bcd_hold", {16'b0, bcd}, {16'b0, eb});
    endtask

    vec_t vecs[$];

    initial begin
        int dn;
        logic [16:0] r;
        checks   = 0;
        errors   = 0;
        prev_bcd = 16'h0000;
        prev_ovf = 1'b0;
        start    = 1'b0;
        bin      = '0;
        clr_n    = 1'b0;

        vecs.push_back('{1234, 16'h1234, 1'b0});
        vecs.push_back('{0, 16'h0000, 1'b0});
        vecs.push_back('{9999, 16'h9999, 1'b0});
        vecs.push_back('{1, 16'h0001, 1'b0});
        vecs.push_back('{10, 16'h0010, 1'b0});
        vecs.push_back('{509, 16'h0509, 1'b0});
        vecs.push_back('{8765, 16'h8765, 1'b0});
`ifdef BCD_SAT_EN
        vecs.push_back('{16383, 16'h9999, 1'b1});
        vecs.push_back('{10000, 16'h9999, 1'b1});
`else
        vecs.push_back('{16383, 16'h6383, 1'b1});
        vecs.push_back('{10000, 16'h0000, 1'b1});
`endif
        vecs.push_back('{42, 16'h0042, 1'b0});

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", {16'b0, bcd}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        clr_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bcd !== 16'h0 || busy !== 1'b0 || done !== 1'b0
                || ovf !== 1'b0)
                chk("idle_hold", {13'b0, busy, done, ovf, bcd}, 32'h0);
        end
        chk("idle_end", {13'b0, busy, done, ovf, bcd}, 32'h0);

        // Vector table
        foreach (vecs[i])
            run_conv(vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_ovf);

        // Start while busy, then back-to-back start in the done cycle
        start = 1'b1;
        bin   = 14'd42;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 14'd777;
        @(posedge clk);
        #1;
        start = 1'b0;
        dn = (done === 1'b1) ? 1 : 0;
        for (int e = 6; e < 14; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        chk("busy_start_no_early_done", dn, 0);
        @(posedge clk);
        #1;
        chk("busy_start_done", {31'b0, done}, 32'd1);
        chk("busy_start_bcd", {16'b0, bcd}, 32'h0042);
        start = 1'b1;
        bin   = 14'd777;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_accepted", {30'b0, busy, done}, 32'd2);
        dn = 0;
        for (int e = 1; e < 14; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        chk("b2b_no_early_done", dn, 0);
        @(posedge clk);
        #1;
        chk("b2b_done", {31'b0, done}, 32'd1);
        chk("b2b_bcd", {16'b0, bcd}, 32'h0777);
        prev_bcd = 16'h0777;
        prev_ovf = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-conversion
        start = 1'b1;
        bin   = 14'd5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        chk("midrst_out", {13'b0, busy, done, ovf, bcd}, 32'h0);
        dn = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
            if (e == 2) clr_n = 1'b1;
        end
        chk("midrst_no_done", dn, 0);
        chk("midrst_bcd_hold", {16'b0, bcd}, 32'h0);
        prev_bcd = 16'h0000;
        prev_ovf = 1'b0;
        run_conv(5678, 16'h5678, 1'b0);

        // Random values against the arithmetic model
        for (int k = 0; k < 1200; k++) begin
            int v;
            v = (k % 8 == 0) ? int'($urandom_range(9990, 10010))
                             : int'($urandom_range(0, 16383));
            r = ref_model(v);
            run_conv(v, r[15:0], r[16]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
